// File: rtl/MIPS_pkg.sv
// Shared MIPS core widths and types used by the memory responder and its word array.
package MIPS_pkg;

  localparam int MIPS_PC_WIDTH       = 32;
  localparam int MIPS_DATA_WIDTH     = 32;
  localparam int MIPS_BYTES_PER_WORD = MIPS_DATA_WIDTH / 8;

  typedef logic [MIPS_BYTES_PER_WORD-1:0] mips_be_t;
  typedef logic [MIPS_PC_WIDTH-1:0]       mips_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } mips_mem_state_e;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word RAM: synchronous byte-enabled write, synchronous read.
module mips_mem_array
  import MIPS_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 256
) (
  input  logic                               clk_i,
  input  logic                               we_i,
  input  logic                               re_i,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] addr_i,
  input  logic [MIPS_DATA_WIDTH-1:0]         wdata_i,
  input  mips_be_t                           be_i,
  output logic [MIPS_DATA_WIDTH-1:0]         rdata_o
);

  logic [MIPS_DATA_WIDTH-1:0] mem_q [MEM_DEPTH_WORDS];
  logic [MIPS_DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset so data survives a core reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MIPS_BYTES_PER_WORD; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES idle cycles, then a single
// array access and a backpressurable response.
module mips_mem_responder
  import MIPS_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int WAIT_STATES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  mips_addr_t                 req_addr,
  input  logic [MIPS_DATA_WIDTH-1:0] req_wdata,
  input  mips_be_t                   req_be,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [MIPS_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_err,
  output mips_mem_state_e            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid-side payload must hold until then, and this block holds rsp_* stable likewise.

  localparam int AW = $clog2(MEM_DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  mips_mem_state_e            state_q;
  logic [CW-1:0]              cnt_q;
  logic                       we_q;
  mips_addr_t                 addr_q;
  logic [MIPS_DATA_WIDTH-1:0] wdata_q;
  mips_be_t                   be_q;
  logic                       ready_q;
  logic                       valid_q;
  logic                       err_q;
  logic                       rd_ok_q;

  logic                       acc_err;
  logic                       arr_we;
  logic                       arr_re;
  logic [MIPS_DATA_WIDTH-1:0] arr_rdata;

  // Out-of-range word indices flag an error rather than aliasing into the array.
  assign acc_err = (addr_q[1:0] != 2'b00) ||
                   ({2'b00, addr_q[MIPS_PC_WIDTH-1:2]} >= 32'(MEM_DEPTH_WORDS));
  assign arr_we  = (state_q == ACCESS) && we_q && !acc_err;
  assign arr_re  = (state_q == ACCESS) && !we_q && !acc_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q <= ACCESS;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CW'(WAIT_STATES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ACCESS;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ACCESS: begin
          err_q   <= acc_err;
          rd_ok_q <= arr_re;
          valid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mips_mem_array #(
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (arr_rdata)
  );

  // The array's read register only loads on a good read, so gating it yields 0 otherwise.
  assign rsp_rdata = rd_ok_q ? arr_rdata : '0;
  assign rsp_err   = err_q;
  assign rsp_valid = valid_q;
  assign req_ready = ready_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: a default build (2 wait states) and a zero-wait build,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_mips_mem_responder;
  import MIPS_pkg::*;

  localparam int DEPTH = 256;
  localparam int WS [2] = '{2, 0};

  logic clk = 1'b0;
  logic rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  mips_mem_state_e dbg_state [2];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_mem_responder #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
  );

  mips_mem_responder #(.MEM_DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- scoreboard / model ----------------
  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          widx;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          acc;
  } txn_t;

  txn_t        exp_q [2][$];
  logic [31:0] ref_mem [int];
  bit          armed = 0;

  function automatic logic [31:0] mem_get(input int d, input int widx);
    if (ref_mem.exists(d * 4096 + widx)) return ref_mem[d * 4096 + widx];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic void commit(input int d, input txn_t t);
    logic [31:0] w;
    if (!t.we || t.err) return;
    w = mem_get(d, t.widx);
    for (int i = 0; i < 4; i++) if (t.be[i]) w[8*i +: 8] = t.wdata[8*i +: 8];
    ref_mem[d * 4096 + t.widx] = w;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit   busy;
      bit   ev;
      txn_t t;
      busy = (exp_q[d].size() != 0);
      if (busy) t = exp_q[d][0];
      ev = busy && (cyc >= t.acc + WS[d] + 2);
      if (armed) begin
        check($sformatf("d%0d req_ready", d), 32'(req_ready[d]), 32'(!busy));
        check($sformatf("d%0d rsp_valid", d), 32'(rsp_valid[d]), 32'(ev));
        if (ev) begin
          check($sformatf("d%0d rsp_rdata", d), rsp_rdata[d], t.rdata);
          check($sformatf("d%0d rsp_err", d), 32'(rsp_err[d]), 32'(t.err));
        end
      end
      if (rst) begin
        if (busy && cyc >= t.acc + WS[d] + 1) commit(d, t);
        exp_q[d].delete();
      end else if (!busy && req_valid[d]) begin
        t.we    = req_we[d];
        t.err   = (req_addr[d][1:0] != 2'b00) || (req_addr[d] >= 32'(DEPTH * 4));
        t.widx  = int'(req_addr[d] >> 2);
        t.wdata = req_wdata[d];
        t.be    = req_be[d];
        t.acc   = cyc;
        t.rdata = (!t.we && !t.err) ? mem_get(d, t.widx) : 32'h0;
        exp_q[d].push_back(t);
      end else if (ev && rsp_ready[d]) begin
        commit(d, t);
        void'(exp_q[d].pop_front());
      end
    end
    if (rst) armed = 1;
  end

  // ---------------- driver ----------------
  // Called and returns just after a rising edge.
  task automatic do_req(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, output logic [31:0] rdata,
                        output logic err, output int lat, output int t_acc, output int t_hs);
    int n;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_be[d] = be; rsp_ready[d] = (hold == 0);
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 40) begin @(negedge clk); n++; end
    check("accept bound", 32'(n < 40), 32'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = ~we; req_addr[d] = ~addr;
    req_wdata[d] = ~wdata; req_be[d] = ~be;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[d] && n < 40) begin @(negedge clk); n++; end
    check("response bound", 32'(n < 40), 32'd1);
    lat = cyc - t_acc; rdata = rsp_rdata[d]; err = rsp_err[d];
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready[d] = 1'b1;
      @(negedge clk);
    end
    t_hs = cyc;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, ta, th, ta2, th2;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_addr[d] = 0;
      req_wdata[d] = 0; req_be[d] = 0; rsp_ready[d] = 1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: write then read back, default build
    do_req(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ta, th);
    check("t1 write latency", 32'(lat), 32'd4);
    check("t1 write err", 32'(er), 32'd0);
    check("t1 write rdata", rd, 32'h0);
    do_req(0, 0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ta, th);
    check("t1 read rdata", rd, 32'hDEADBEEF);

    // 2: byte enables
    do_req(0, 1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, ta, th);
    do_req(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, ta, th);
    do_req(0, 0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, ta, th);
    check("t2 merged word", rd, 32'h11BB33DD);
    do_req(0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, ta, th);
    check("t2 be0 err", 32'(er), 32'd0);

    // 3: misaligned, out of range, last word
    do_req(0, 1, 32'h0, 32'hA5A50F0F, 4'hF, 0, rd, er, lat, ta, th);
    do_req(0, 0, 32'h13, 32'h0, 4'hF, 0, rd, er, lat, ta, th);
    check("t3 misaligned err", 32'(er), 32'd1);
    check("t3 misaligned rdata", rd, 32'h0);
    do_req(0, 1, 32'h400, 32'h5555AAAA, 4'hF, 0, rd, er, lat, ta, th);
    check("t3 range err", 32'(er), 32'd1);
    do_req(0, 0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat, ta, th);
    check("t3 no alias", rd, 32'hA5A50F0F);
    do_req(0, 1, 32'h3FC, 32'h600DF00D, 4'hF, 0, rd, er, lat, ta, th);
    do_req(0, 0, 32'h3FC, 32'h0, 4'hF, 0, rd, er, lat, ta, th);
    check("t3 last word", rd, 32'h600DF00D);
    check("t3 last word err", 32'(er), 32'd0);

    // 4: backpressure with a second request waiting
    fork
      do_req(0, 0, 32'h10, 32'h0, 4'hF, 5, rd, er, lat, ta, th);
      begin
        repeat (2) @(posedge clk);
        #2;
        req_valid[0] = 1; req_we[0] = 0; req_addr[0] = 32'h20;
        req_wdata[0] = 32'h0; req_be[0] = 4'hF;
      end
    join
    check("t4 held rdata", rd, 32'hDEADBEEF);
    check("t4 hold length", 32'(th - ta), 32'd9);
    do_req(0, 0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, ta2, th2);
    check("t4 next accept", 32'(ta2 - th), 32'd1);
    check("t4 second rdata", rd, 32'h11BB33DD);

    // 5: zero-wait build
    do_req(1, 1, 32'h4, 32'h0BADCAFE, 4'hF, 0, rd, er, lat, ta, th);
    check("t5 write latency", 32'(lat), 32'd2);
    do_req(1, 0, 32'h4, 32'h0, 4'hF, 0, rd, er, lat, ta2, th2);
    check("t5 read latency", 32'(lat), 32'd2);
    check("t5 read rdata", rd, 32'h0BADCAFE);
    check("t5 accept spacing", 32'(ta2 - ta), 32'd3);

    // 6: reset in WAIT drops an in-flight write; reset beats a simultaneous request
    do_req(0, 1, 32'h8, 32'h12345678, 4'hF, 0, rd, er, lat, ta, th);
    req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h8;
    req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
    @(negedge clk);
    check("t6 accept", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 0;
    rst = 1; req_valid[1] = 1; req_we[1] = 0; req_addr[1] = 32'h4;
    @(posedge clk); #1;
    rst = 0; req_valid[1] = 0;
    @(negedge clk);
    check("t6 ready after rst", 32'(req_ready[0]), 32'd1);
    check("t6 valid after rst", 32'(rsp_valid[0]), 32'd0);
    check("t6 rst beats req", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    do_req(0, 0, 32'h8, 32'h0, 4'hF, 0, rd, er, lat, ta, th);
    check("t6 old word kept", rd, 32'h12345678);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
Memory-side responder for the multi-cycle MIPS core's unified instruction/data memory port. The core's control FSM issues word-aligned read or write requests. This block accepts one request at a time, models a configurable number of wait states, and performs the access on an internal word-organised array with byte enables. It returns read data or an error flag through a response handshake that the core may backpressure.

Parameters:
MEM_DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, minimum 4.
WAIT_STATES, 2, idle cycles between request acceptance and the array access; 0 allowed.

Ports:
clk  in  1  core clock; all logic is rising-edge.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  core presents a request.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = write, 0 = read.
req_addr  in  MIPS_PC_WIDTH (32)  byte address.
req_wdata  in  MIPS_DATA_WIDTH (32)  write data.
req_be  in  4  byte enables; bit i selects wdata[8i+7:8i].
rsp_valid  out  1  response available.
rsp_ready  in  1  core accepts the response.
rsp_rdata  out  MIPS_DATA_WIDTH (32)  read data; 0 for writes and errors.
rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not cleared by reset and persist across it.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register we/addr/wdata/be.
  - Go to WAIT with counter=WAIT_STATES-1, or go straight to ACCESS if WAIT_STATES==0.
- WAIT:
  - req_ready=0; decrement counter each cycle.
  - Leave for ACCESS in the cycle the counter is 0.
- ACCESS (exactly one cycle):
  - Error check: err = (addr[1:0]!=0) || (addr[31:2] >= MEM_DEPTH_WORDS).
  - Write with no error: update only the enabled bytes of word addr[31:2].
  - Read with no error: capture that word into rsp_rdata.
  - Error: no array update; rsp_rdata=0, rsp_err=1.
  - Write: rsp_rdata=0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready.
  - On handshake, return to IDLE; rsp_valid=0 and req_ready=1 in the next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency: request handshake at cycle T gives rsp_valid first high at cycle T+WAIT_STATES+2.
- Throughput: one request per WAIT_STATES+3 cycles when rsp_ready is tied high.
- Held inputs: changes to req_* after acceptance are ignored.
- req_be=0 on a valid write: legal; the array is unchanged and rsp_err=0.
- Reads ignore req_be and req_wdata.
- Reset mid-operation (any state):
  - Return to IDLE and drop any pending response.
  - A write that has not reached ACCESS must not modify the array.
  - A write already completed in ACCESS is retained.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.
- Address wrap: none. Addresses at or beyond MEM_DEPTH_WORDS*4 set rsp_err; they do not alias.

Decomposition:
- Add to MIPS_pkg:
  - MIPS_BYTES_PER_WORD = MIPS_DATA_WIDTH/8.
  - typedef mips_be_t = logic[MIPS_BYTES_PER_WORD-1:0].
  - typedef mips_addr_t = logic[MIPS_PC_WIDTH-1:0].
  - enum mips_mem_state_e {IDLE, WAIT, ACCESS, RESP}.
- One sub-module: mips_mem_array.
  - Single-port, synchronous-write, synchronous-read word RAM with byte-enable write.
  - Parameter MEM_DEPTH_WORDS.
  - Instantiated once.
  - The FSM, counter and error check stay in mips_mem_responder.

Test Plan:
1. Default params: after reset, write addr=0x10, wdata=0xDEADBEEF, be=4'hF, rsp_ready=1 -> req_ready=0 for 4 cycles, rsp_valid 4 cycles after acceptance, rsp_err=0, rsp_rdata=0. Then read 0x10 -> rsp_rdata=0xDEADBEEF.
2. Byte enables: word 0x20 initialised to 0x11223344, then write wdata=0xAABBCCDD be=4'b0101 -> read 0x20 returns 0x11BB33DD.
3. Errors: read 0x13 (misaligned) -> rsp_err=1, rsp_rdata=0. Write 0x400 (word 256, out of range) -> rsp_err=1, and a read of 0x0 is unchanged (no alias).
4. Backpressure: read with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable for all 5 cycles. req_ready stays 0; a second req_valid is not accepted until the cycle after rsp_ready=1.
5. WAIT_STATES=0 build: read request at T -> rsp_valid at T+2; back-to-back requests with rsp_ready=1 are accepted every 3 cycles.
6. Reset in WAIT during a write to 0x8 (old value 0x12345678) -> next cycle req_ready=1, rsp_valid=0. A subsequent read of 0x8 returns 0x12345678.
